// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with one write port, two
// combinational read ports, a per-register pending scoreboard and a
// hardware clear sequencer that sweeps every register to zero.
// Optional feature macro: RF_BYPASS_EN. When it is defined, IDLE-state
// writes are forwarded combinationally to matching read ports. The
// default build (macro undefined) returns stored state only.
module reg_file_sb #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          WEN,
  input  logic [AW-1:0] RW,
  input  logic [DW-1:0] busW,
  input  logic [AW-1:0] RX,
  input  logic [AW-1:0] RY,
  output logic [DW-1:0] busX,
  output logic [DW-1:0] busY,
  input  logic          RSV,
  input  logic [AW-1:0] RR,
  output logic          PendX,
  output logic          PendY,
  input  logic          CLR,
  output logic          BUSY
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            idle;

  // Flattened views of all register contents and pending bits.
  logic [DEPTH-1:0][DW-1:0] data_vec;
  logic [DEPTH-1:0]         pend_vec;

  assign idle = (state_reg == IDLE);
  assign BUSY = busy_reg;

  // Clear sequencer: IDLE waits for CLR, CLEAR walks cnt over every register once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (CLR) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          // cnt wraps to zero naturally on the last register
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        // Hardwired zero register: never stores data, never pending.
        assign data_vec[gi] = '0;
        assign pend_vec[gi] = 1'b0;
      end else begin : g_live
        localparam logic [AW-1:0] IDX = AW'(gi);

        logic [DW-1:0] data_reg;
        logic          pend_reg;
        logic          wr_hit;
        logic          rsv_hit;
        logic          clr_hit;

        assign wr_hit  = idle && WEN && (RW == IDX);
        assign rsv_hit = idle && RSV && (RR == IDX);
        assign clr_hit = !idle && (cnt_reg == IDX);

        // Data storage: written by the write port in IDLE, zeroed by the sweep.
        always_ff @(posedge Clk or negedge Rst_n) begin
          if (!Rst_n) begin
            data_reg <= '0;
          end else if (clr_hit) begin
            data_reg <= '0;
          end else if (wr_hit) begin
            data_reg <= busW;
          end
        end

        // Pending bit: a reserve beats a same-cycle write to the same register.
        always_ff @(posedge Clk or negedge Rst_n) begin
          if (!Rst_n) begin
            pend_reg <= 1'b0;
          end else if (clr_hit) begin
            pend_reg <= 1'b0;
          end else if (rsv_hit) begin
            pend_reg <= 1'b1;
          end else if (wr_hit) begin
            pend_reg <= 1'b0;
          end
        end

        assign data_vec[gi] = data_reg;
        assign pend_vec[gi] = pend_reg;
      end
    end
  endgenerate

`ifdef RF_BYPASS_EN
  logic fwd_x;
  logic fwd_y;
  logic wr_ok;

  // Register 0 is not a forwarding source when it is hardwired.
  assign wr_ok = !(ZERO_REG != 0 && RW == '0);
  assign fwd_x = idle && WEN && wr_ok && (RW == RX);
  assign fwd_y = idle && WEN && wr_ok && (RW == RY);

  // Read ports with write-to-read forwarding; the pending bit of a forwarded
  // register reflects only a same-cycle reserve.
  always_comb begin
    busX  = data_vec[RX];
    busY  = data_vec[RY];
    PendX = pend_vec[RX];
    PendY = pend_vec[RY];
    if (fwd_x) begin
      busX  = busW;
      PendX = RSV && (RR == RX);
    end
    if (fwd_y) begin
      busY  = busW;
      PendY = RSV && (RR == RY);
    end
  end
`else
  // Read ports return stored state only.
  always_comb begin
    busX  = data_vec[RX];
    busY  = data_vec[RY];
    PendX = pend_vec[RX];
    PendY = pend_vec[RY];
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: drives two reg_file_sb instances (ZERO_REG=1 and
// ZERO_REG=0) with the same directed and randomized stimulus and compares
// both against an array-based reference model.
module tb_reg_file_sb;

  logic       Clk;
  logic       Rst_n;
  logic       WEN;
  logic [2:0] RW;
  logic [7:0] busW;
  logic [2:0] RX;
  logic [2:0] RY;
  logic       RSV;
  logic [2:0] RR;
  logic       CLR;

  logic [7:0] busX,   busY;
  logic       PendX,  PendY,  BUSY;
  logic [7:0] busX_n, busY_n;
  logic       PendX_n, PendY_n, BUSY_n;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0.
  logic [7:0] mr [2][8];
  bit         mp [2][8];
  bit         m_busy;
  int         m_pos;

  reg_file_sb #(.DW(8), .AW(3), .ZERO_REG(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WEN(WEN), .RW(RW), .busW(busW),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .RSV(RSV), .RR(RR), .PendX(PendX), .PendY(PendY),
    .CLR(CLR), .BUSY(BUSY)
  );

  reg_file_sb #(.DW(8), .AW(3), .ZERO_REG(0)) dut_nz (
    .Clk(Clk), .Rst_n(Rst_n), .WEN(WEN), .RW(RW), .busW(busW),
    .RX(RX), .RY(RY), .busX(busX_n), .busY(busY_n),
    .RSV(RSV), .RR(RR), .PendX(PendX_n), .PendY(PendY_n),
    .CLR(CLR), .BUSY(BUSY_n)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_ok(input int z, input int a);
    return !(z == 0 && a == 0);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int a = 0; a < 8; a++) begin
        mr[z][a] = 8'h00;
        mp[z][a] = 1'b0;
      end
    m_busy = 1'b0;
    m_pos  = 0;
  endtask

  // Register file behaviour at one rising edge, from the current inputs.
  task automatic model_update();
    if (!m_busy) begin
      for (int z = 0; z < 2; z++) begin
        if (WEN && wr_ok(z, int'(RW))) begin
          mr[z][RW] = busW;
          mp[z][RW] = 1'b0;
        end
        if (RSV && wr_ok(z, int'(RR)))
          mp[z][RR] = 1'b1;
      end
      if (CLR) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end
    end else begin
      for (int z = 0; z < 2; z++) begin
        mr[z][m_pos] = 8'h00;
        mp[z][m_pos] = 1'b0;
      end
      m_pos++;
      if (m_pos == 8) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end
    end
  endtask

  task automatic check_inst(input int z, input logic [7:0] bx, input logic [7:0] by,
                            input logic px, input logic py, input logic bsy);
    logic [7:0] ex, ey;
    bit epx, epy;
    string pre;
    pre = (z == 0) ? "z1" : "z0";
    ex  = mr[z][RX];
    ey  = mr[z][RY];
    epx = mp[z][RX];
    epy = mp[z][RY];
`ifdef RF_BYPASS_EN
    if (!m_busy && WEN && wr_ok(z, int'(RW))) begin
      if (RW == RX) begin
        ex  = busW;
        epx = RSV && (RR == RX);
      end
      if (RW == RY) begin
        ey  = busW;
        epy = RSV && (RR == RY);
      end
    end
`endif
    check({pre, "_busX"}, bx, ex);
    check({pre, "_busY"}, by, ey);
    check({pre, "_PendX"}, px, epx);
    check({pre, "_PendY"}, py, epy);
    check({pre, "_BUSY"}, bsy, m_busy);
  endtask

  task automatic check_all();
    check_inst(0, busX, busY, PendX, PendY, BUSY);
    check_inst(1, busX_n, busY_n, PendX_n, PendY_n, BUSY_n);
  endtask

  // Drive one cycle of inputs at the falling edge and check outputs.
  task automatic apply(input bit wen, input int rw, input int bw, input bit rsv,
                       input int rr, input bit clr, input int rx, input int ry);
    logic [31:0] t_rw, t_bw, t_rr, t_rx, t_ry;
    t_rw = rw; t_bw = bw; t_rr = rr; t_rx = rx; t_ry = ry;
    @(negedge Clk);
    WEN  = wen;
    RW   = t_rw[2:0];
    busW = t_bw[7:0];
    RSV  = rsv;
    RR   = t_rr[2:0];
    CLR  = clr;
    RX   = t_rx[2:0];
    RY   = t_ry[2:0];
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
  endtask

  task automatic mid_reset(input int rx, input int ry);
    logic [31:0] t_rx, t_ry;
    t_rx = rx; t_ry = ry;
    @(negedge Clk);
    WEN = 1'b0; RSV = 1'b0; CLR = 1'b0;
    RX = t_rx[2:0];
    RY = t_ry[2:0];
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_busX", busX, 8'h00);
    check("rst_BUSY", BUSY, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Start a sweep; abort_at >= 0 asserts reset in that sweep cycle.
  task automatic sweep(input int abort_at);
    apply(0, 0, 0, 0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 7));
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        mid_reset(k, $urandom_range(0, 7));
        return;
      end
      apply(1, $urandom_range(0, 7), $urandom_range(1, 255), 1,
            $urandom_range(0, 7), 1, k, $urandom_range(0, 7));
      check("busy_sweep", BUSY, 1'b1);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 7);
    check("busy_done", BUSY, 1'b0);
    tick();
  endtask

  initial begin
    Rst_n = 1'b0;
    WEN = 1'b0; RW = '0; busW = '0; RX = '0; RY = '0;
    RSV = 1'b0; RR = '0; CLR = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge Clk);
    Rst_n = 1'b1;

    // Write then read, then asynchronous reset mid-cycle.
    apply(1, 3, 8'hA5, 0, 0, 0, 3, 3); tick();
    apply(0, 0, 0, 0, 0, 0, 3, 3);
    check("wr_busX", busX, 8'hA5);
    check("wr_busY", busY, 8'hA5);
    tick();
    mid_reset(3, 3);

    // Zero register behaviour on both instances.
    apply(1, 0, 8'hFF, 1, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("z1_r0_bus",  busX,    8'h00);
    check("z1_r0_pend", PendX,   1'b0);
    check("z0_r0_bus",  busX_n,  8'hFF);
    check("z0_r0_pend", PendX_n, 1'b1);
    tick();

    // Scoreboard: reserve, clear by write, write+reserve together.
    apply(0, 0, 0, 1, 5, 0, 5, 5); tick();
    apply(0, 0, 0, 0, 0, 0, 5, 5);
    check("rsv_pend", PendX, 1'b1);
    tick();
    apply(1, 5, 8'h3C, 0, 0, 0, 1, 1); tick();
    apply(0, 0, 0, 0, 0, 0, 5, 5);
    check("wr_unpend", PendX, 1'b0);
    tick();
    apply(1, 5, 8'h77, 1, 5, 0, 1, 1); tick();
    apply(0, 0, 0, 0, 0, 0, 5, 5);
    check("wrsv_bus",  busX,  8'h77);
    check("wrsv_pend", PendX, 1'b1);
    tick();

    // Forwarding: r4 = 0x10 pending, then write 0x99 while reading it.
    apply(1, 4, 8'h10, 1, 4, 0, 0, 0); tick();
    apply(1, 4, 8'h99, 0, 0, 0, 4, 4);
`ifdef RF_BYPASS_EN
    check("byp_bus",  busX,  8'h99);
    check("byp_pend", PendX, 1'b0);
`else
    check("nobyp_bus",  busX,  8'h10);
    check("nobyp_pend", PendX, 1'b1);
`endif
    tick();
    apply(0, 0, 0, 0, 0, 0, 4, 4);
    check("post_bus",  busX,  8'h99);
    check("post_pend", PendX, 1'b0);
    tick();

    // Full sweep after filling r1..r7 with nonzero data and pend.
    for (int a = 1; a < 8; a++) begin
      apply(1, a, 8'h10 * a + a, 1, a, 0, a, 8 - a); tick();
    end
    sweep(-1);
    for (int a = 0; a < 8; a++) begin
      apply(0, 0, 0, 0, 0, 0, a, 7 - a); tick();
    end
    apply(1, 2, 8'h11, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 2, 2);
    check("post_clr_wr", busX, 8'h11);
    tick();

    // Reset at sweep cycle 3, then a fresh full sweep.
    for (int a = 1; a < 8; a++) begin
      apply(1, a, 8'hE0 + a, 1, a, 0, a, a); tick();
    end
    sweep(3);
    for (int a = 0; a < 8; a++) begin
      apply(0, 0, 0, 0, 0, 0, a, a); tick();
    end
    sweep(-1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset($urandom_range(0, 7), $urandom_range(0, 7));
      end else begin
        apply($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
              ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
              ($urandom_range(0, 39) == 0),
              $urandom_range(0, 7), $urandom_range(0, 7));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
